// File: rtl/gfx_serial_tx_if.sv
// rtl/gfx_serial_tx_if.sv - byte handshake bundle between the graphics controller and the serializer
//
// Purpose: carries one byte per accepted transfer from the upstream graphics
// controller into gfx_serial_tx.
//
// Signals:
//   IN_VALID   upstream byte valid (driven by master)
//   IN_DATA    upstream byte, taken when IN_VALID && OUT_READY (driven by master)
//   OUT_READY  serializer can take a byte this cycle (driven by slave)
//
// Modports:
//   master  upstream side (graphics controller / testbench)
//   slave   serializer side
interface gfx_serial_tx_if;
   logic       IN_VALID;
   logic [7:0] IN_DATA;
   logic       OUT_READY;

   modport master (
      output IN_VALID,
      output IN_DATA,
      input  OUT_READY
   );

   modport slave (
      input  IN_VALID,
      input  IN_DATA,
      output OUT_READY
   );
endinterface

// File: rtl/gfx_serial_tx.sv
// rtl/gfx_serial_tx.sv - FIFO-buffered 8N1 UART serializer for the graphics controller TX pin
//
// Purpose: accepts bytes over a valid/ready handshake into a small FIFO and
// sends each one as an 8N1 UART frame, LSB first, on the board serial line.
// Frames leave back to back with no idle gap while the FIFO holds data.
//
// Parameters:
//   CLKS_PER_BIT    CLK cycles per serial bit (2..65535)
//   FIFO_ADDR_BITS  log2 of the FIFO depth
//
// Ports:
//   CLK             system clock, rising edge
//   RESET           synchronous, active-high reset
//   in_if           byte handshake (slave side): IN_VALID, IN_DATA, OUT_READY
//   OUT_SERIAL_TX   UART line, idle high, registered
//   OUT_BUSY        frame on the line or FIFO non-empty, registered
//   OUT_FIFO_LEVEL  bytes currently stored (0..2^FIFO_ADDR_BITS)
module gfx_serial_tx #(
   parameter int CLKS_PER_BIT   = 434,
   parameter int FIFO_ADDR_BITS = 4
) (
   input  logic                    CLK,
   input  logic                    RESET,
   gfx_serial_tx_if.slave          in_if,
   output logic                    OUT_SERIAL_TX,
   output logic                    OUT_BUSY,
   output logic [FIFO_ADDR_BITS:0] OUT_FIFO_LEVEL
);

   localparam int                      DEPTH    = 1 << FIFO_ADDR_BITS;
   localparam logic [FIFO_ADDR_BITS:0] LVL_FULL = (FIFO_ADDR_BITS + 1)'(DEPTH);
   localparam logic [FIFO_ADDR_BITS:0] LVL_ONE  = (FIFO_ADDR_BITS + 1)'(1);
   localparam logic [FIFO_ADDR_BITS:0] LVL_ZERO = '0;
   localparam logic [FIFO_ADDR_BITS-1:0] PTR_ONE = (FIFO_ADDR_BITS)'(1);
   localparam logic [15:0]             BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t                    state_q, state_d;
   logic [15:0]               baud_q, baud_d;
   logic [2:0]                bit_idx_q, bit_idx_d;
   logic [7:0]                shift_q, shift_d;
   logic                      tx_q, tx_d;
   logic                      busy_q, busy_d;
   logic                      ready_q, ready_d;
   logic [FIFO_ADDR_BITS:0]   level_q, level_d;
   logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]                mem_q [DEPTH];
   logic [7:0]                mem_d [DEPTH];

   logic push;
   logic pop;
   logic bit_end;
   logic fifo_has_data;

   // Push is qualified by the registered ready, so a pop in the same cycle
   // cannot open a slot in a full FIFO until the following cycle.
   assign push          = in_if.IN_VALID && ready_q;
   assign bit_end       = (baud_q == BAUD_LAST);
   // Uses the level before this edge's push, so a byte written this edge is
   // not visible to a pop on the same edge.
   assign fifo_has_data = (level_q != LVL_ZERO);

   // Transmit FSM: next state, line value and pop request.
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      pop       = 1'b0;

      case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            baud_d = '0;
            if (fifo_has_data) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               tx_d    = 1'b0;
               state_d = START;
            end
         end

         START: begin
            if (bit_end) begin
               baud_d    = '0;
               tx_d      = shift_q[0];
               bit_idx_d = '0;
               state_d   = DATA;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end

         DATA: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  // Shift right and drive the next LSB in the same edge.
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_d      = shift_q[1];
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end

         STOP: begin
            if (bit_end) begin
               baud_d = '0;
               if (fifo_has_data) begin
                  // Straight into the next start bit: no idle gap.
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  tx_d    = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end

         default: begin
            tx_d    = 1'b1;
            baud_d  = '0;
            state_d = IDLE;
         end
      endcase
   end

   // FIFO bookkeeping and registered status outputs.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      mem_d    = mem_q;

      if (push) begin
         mem_d[wr_ptr_q] = in_if.IN_DATA;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      case ({push, pop})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase

      ready_d = (level_d != LVL_FULL);
      busy_d  = (state_d != IDLE) || (level_d != LVL_ZERO);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         ready_q   <= 1'b1;
         level_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
         level_q   <= level_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   // Storage needs no reset: clearing the pointers and level discards it.
   always_ff @(posedge CLK) begin
      mem_q <= mem_d;
   end

   assign in_if.OUT_READY = ready_q;
   assign OUT_SERIAL_TX   = tx_q;
   assign OUT_BUSY        = busy_q;
   assign OUT_FIFO_LEVEL  = level_q;

endmodule

// File: doc/gfx_serial_tx.md
Name: gfx_serial_tx

Overview:
Byte-stream serializer downstream of the graphics controller. It accepts pixel/frame bytes over a valid/ready handshake and buffers them in a small FIFO. It emits them on the board serial line as 8N1 UART frames, LSB first. Its serial output is the controller's top-level serial TX pin.

Parameters:
CLKS_PER_BIT, 434, CLK cycles per serial bit (50 MHz / 115200); legal range 2..65535.
FIFO_ADDR_BITS, 4, log2 of FIFO depth (default depth 16 bytes).

Ports:
CLK  input  1  system clock; all logic on rising edge.
RESET  input  1  synchronous, active-high reset.
IN_VALID  input  1  upstream byte valid.
IN_DATA  input  8  upstream byte; sampled when IN_VALID && OUT_READY.
OUT_READY  output  1  FIFO can accept a byte this cycle (= not full, registered).
OUT_SERIAL_TX  output  1  UART line, idle high, registered.
OUT_BUSY  output  1  high while a frame is on the line or the FIFO is non-empty.
OUT_FIFO_LEVEL  output  FIFO_ADDR_BITS+1  bytes currently stored (0..2^FIFO_ADDR_BITS).

Behaviour:
- Reset (synchronous, active-high; clock CLK) holds for any cycle RESET=1:
  - OUT_SERIAL_TX=1, OUT_READY=1, OUT_BUSY=0, OUT_FIFO_LEVEL=0.
  - FSM goes to IDLE; FIFO pointers and the bit/baud counters clear.
  - Reset mid-frame aborts the frame: line high on the next edge, FIFO contents discarded.
- Push: on an edge with IN_VALID=1 and OUT_READY=1, IN_DATA is written at the write pointer and the level is incremented.
  - IN_VALID with OUT_READY=0 is ignored; the byte is not latched and upstream must hold it.
- OUT_READY=0 exactly when the level equals 2^FIFO_ADDR_BITS.
  - A pop in the same cycle does not make a full FIFO accept a push that cycle; ready rises the following cycle.
- Pointers wrap modulo 2^FIFO_ADDR_BITS. Simultaneous push and pop (not full) leaves the level unchanged.
- FSM states IDLE, START, DATA, STOP. Baud counter counts 0..CLKS_PER_BIT-1; a bit ends when it reaches CLKS_PER_BIT-1.
  - IDLE: line=1. If the FIFO is non-empty: pop the head into the shift register, line<=0, counter<=0, go to START.
  - START: line=0 for CLKS_PER_BIT cycles. At bit end: line<=shift[0], bit index<=0, go to DATA.
  - DATA: each bit end shifts right and drives the next LSB. After bit index 7 ends: line<=1, go to STOP.
  - STOP: line=1 for CLKS_PER_BIT cycles. At bit end:
    - FIFO non-empty: pop, line<=0, go straight to START (no idle gap between back-to-back frames).
    - Otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Latency: byte pushed at edge N into an empty FIFO while IDLE gives the pop and line=0 at edge N+1. The start bit is visible after edge N+1.
- A byte pushed into an empty FIFO on the same edge a pop would occur is not visible to that pop; it is popped on the next eligible edge.
- OUT_BUSY = (state != IDLE) || (level != 0), registered. It falls on the edge the FSM enters IDLE with an empty FIFO.
- Data bits are sent in order IN_DATA[0] first through IN_DATA[7]. Data is never altered or reordered; FIFO order is preserved.

Test Plan:
- Single byte (CLKS_PER_BIT=4): push 8'hA5 once after reset.
  - Line goes low 1 cycle after the push and holds 4 cycles.
  - Bits follow as 1,0,1,0,0,1,0,1, 4 cycles each, then stop high 4 cycles.
  - OUT_BUSY drops on the same edge as IDLE entry (41 cycles after the push).
- Back-to-back: push 8'h00, 8'hFF on consecutive cycles.
  - Exactly 80 cycles from the first start-bit edge to the second frame's stop-bit end.
  - No idle cycle between the stop of frame 1 and the start of frame 2.
- FIFO full (FIFO_ADDR_BITS=2): hold IN_VALID with bytes 1..8.
  - The first byte is popped immediately, so OUT_READY falls after 5 accepts and OUT_FIFO_LEVEL reads 4.
  - Each later accept occurs only after a pop.
  - Serial output decodes exactly 1..8 in order.
- Ignored push: while OUT_READY=0, present 8'h3C for 1 cycle, then drop IN_VALID.
  - 8'h3C never appears on the line; the level is unchanged.
- Reset mid-frame: assert RESET during the DATA bit 3 of 8'h55 with 2 bytes queued.
  - Next edge: line=1, OUT_FIFO_LEVEL=0, OUT_BUSY=0, OUT_READY=1.
  - No further start bit until a new push.
- Wrap-around: stream 40 incrementing bytes with FIFO_ADDR_BITS=2 and random IN_VALID gaps.
  - Decoded stream is 0..39 in order; level never exceeds 4.
